// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared run-control types and program entry points
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_fsm_t;

    typedef logic [1:0] prog_sel_t;

    // PC entry points: select 0/2 park at PROG1_ENTRY, 1/3 at PROG23_ENTRY
    localparam int PROG1_ENTRY  = -1;
    localparam int PROG23_ENTRY = 106;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and enable
// Ports: CLK clock; clr synchronous clear (wins over en); en count enable;
//        count current value, holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - run-control sequencer ahead of the program counter
// Ports: CLK, reset (sync, active-high); start, halt requests;
//        state program select to PC; pc_reset PC park; run processor enable;
//        done completion pulse; timeout sticky limit flag; cycle_count run length.
module run_sequencer
    import proc_pkg::*;
#(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] TIMEOUT = {CNT_W{1'b1}}
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    output prog_sel_t        state,
    output logic             pc_reset,
    output logic             run,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    run_fsm_t  fsm;
    run_fsm_t  fsm_nxt;
    prog_sel_t state_nxt;
    logic      timeout_nxt;
    logic      cnt_clr;
    logic      cnt_en;
    logic      limit_hit;

    // Compare against TIMEOUT-1 so the count lands exactly on TIMEOUT at exit.
    assign limit_hit = (TIMEOUT != '0) && (cycle_count == (TIMEOUT - 1'b1));

    always_comb begin
        fsm_nxt     = fsm;
        state_nxt   = state;
        timeout_nxt = timeout;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (fsm)
            IDLE: begin
                if (start) begin
                    fsm_nxt     = RUN;
                    cnt_clr     = 1'b1;
                    timeout_nxt = 1'b0;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                // Halt takes priority over a coincident limit hit.
                if (halt) begin
                    fsm_nxt = DONE;
                end else if (limit_hit) begin
                    fsm_nxt     = DONE;
                    timeout_nxt = 1'b1;
                end
            end
            DONE: begin
                fsm_nxt   = IDLE;
                state_nxt = state + 2'd1;
            end
            default: begin
                fsm_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            fsm     <= IDLE;
            state   <= '0;
            timeout <= 1'b0;
        end else begin
            fsm     <= fsm_nxt;
            state   <= state_nxt;
            timeout <= timeout_nxt;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .CLK   (CLK),
        .clr   (reset | cnt_clr),
        .en    (cnt_en),
        .count (cycle_count)
    );

    // PC is held parked in every non-RUN cycle so it keeps reloading the entry.
    assign pc_reset = (fsm != RUN);
    assign run      = (fsm == RUN);
    assign done     = (fsm == DONE);

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - self-checking bench for run_sequencer
module tb_run_sequencer;

    localparam int LIMIT = 10;

    typedef struct packed {
        logic [1:0]  st;
        logic        pcr;
        logic        run;
        logic        done;
        logic        tmo;
        logic [15:0] cnt;
    } out_t;

    typedef struct {
        logic r;
        logic s;
        logic h;
        out_t exp;
    } vec_t;

    logic        CLK;
    logic        reset;
    logic        start;
    logic        halt;
    logic [1:0]  state;
    logic        pc_reset;
    logic        run;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;

    int   checks;
    int   errors;
    int   exp_st;
    vec_t tbl [21];
    out_t exp_q [$];

    run_sequencer #(
        .CNT_W   (16),
        .TIMEOUT (16'(LIMIT))
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .halt        (halt),
        .state       (state),
        .pc_reset    (pc_reset),
        .run         (run),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic out_t o(input int st, input int pcr, input int rn,
                               input int dn, input int tmo, input int cnt);
        out_t x;
        x.st   = st[1:0];
        x.pcr  = pcr[0];
        x.run  = rn[0];
        x.done = dn[0];
        x.tmo  = tmo[0];
        x.cnt  = cnt[15:0];
        return x;
    endfunction

    task automatic tv(input int i, input int r, input int s, input int h,
                      input int st, input int pcr, input int rn,
                      input int dn, input int tmo, input int cnt);
        tbl[i].r   = r[0];
        tbl[i].s   = s[0];
        tbl[i].h   = h[0];
        tbl[i].exp = o(st, pcr, rn, dn, tmo, cnt);
    endtask

    task automatic step(input string tag, input logic r, input logic s,
                        input logic h, input out_t e);
        out_t got;
        out_t want;
        @(negedge CLK);
        reset = r;
        start = s;
        halt  = h;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        got.st   = state;
        got.pcr  = pc_reset;
        got.run  = run;
        got.done = done;
        got.tmo  = timeout;
        got.cnt  = cycle_count;
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got st=%0d pcr=%b run=%b done=%b tmo=%b cnt=%0d, want st=%0d pcr=%b run=%b done=%b tmo=%b cnt=%0d",
                     tag, got.st, got.pcr, got.run, got.done, got.tmo, got.cnt,
                     want.st, want.pcr, want.run, want.done, want.tmo, want.cnt);
        end
    endtask

    // halt_at = 0 means never halt; exit is then forced at the LIMIT-th cycle.
    task automatic run_prog(input int halt_at);
        int e;
        int tmo;
        e   = (halt_at != 0 && halt_at <= LIMIT) ? halt_at : LIMIT;
        tmo = (halt_at == 0 || halt_at > LIMIT) ? 1 : 0;
        step("run_start", 1'b0, 1'b1, 1'b0, o(exp_st, 0, 1, 0, 0, 0));
        for (int k = 1; k < e; k++) begin
            step("run_count", 1'b0, 1'b0, 1'b0, o(exp_st, 0, 1, 0, 0, k));
        end
        step("run_end", 1'b0, 1'b0, (halt_at == e), o(exp_st, 1, 0, 1, tmo, e));
        exp_st = (exp_st + 1) % 4;
        step("run_idle", 1'b0, 1'b0, 1'b0, o(exp_st, 1, 0, 0, tmo, e));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        halt   = 1'b0;

        //   i  r  s  h  st pcr run dn tmo cnt
        tv( 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);   // reset state
        tv( 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);   // halt in IDLE ignored
        tv( 2, 0, 1, 0, 0, 0, 1, 0, 0, 0);   // start -> RUN
        tv( 3, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        tv( 4, 0, 1, 0, 0, 0, 1, 0, 0, 2);   // start in RUN ignored
        tv( 5, 0, 0, 0, 0, 0, 1, 0, 0, 3);
        tv( 6, 0, 0, 0, 0, 0, 1, 0, 0, 4);
        tv( 7, 0, 0, 1, 0, 1, 0, 1, 0, 5);   // halt on 5th RUN cycle
        tv( 8, 0, 1, 1, 1, 1, 0, 0, 0, 5);   // start/halt in DONE ignored
        tv( 9, 0, 1, 1, 1, 0, 1, 0, 0, 0);   // start+halt in IDLE -> RUN
        tv(10, 0, 0, 0, 1, 0, 1, 0, 0, 1);
        tv(11, 0, 0, 0, 1, 0, 1, 0, 0, 2);
        tv(12, 0, 0, 0, 1, 0, 1, 0, 0, 3);
        tv(13, 0, 0, 0, 1, 0, 1, 0, 0, 4);
        tv(14, 0, 0, 0, 1, 0, 1, 0, 0, 5);
        tv(15, 0, 0, 0, 1, 0, 1, 0, 0, 6);
        tv(16, 0, 0, 0, 1, 0, 1, 0, 0, 7);
        tv(17, 1, 1, 1, 0, 1, 0, 0, 0, 0);   // reset mid-RUN beats start/halt
        tv(18, 0, 1, 1, 0, 0, 1, 0, 0, 0);
        tv(19, 0, 0, 1, 0, 1, 0, 1, 0, 1);   // halt on first RUN cycle
        tv(20, 0, 0, 0, 1, 1, 0, 0, 0, 1);

        for (int i = 0; i < 21; i++) begin
            step($sformatf("vec%0d", i), tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].exp);
        end

        step("wrap_reset", 1'b1, 1'b0, 1'b0, o(0, 1, 0, 0, 0, 0));
        exp_st = 0;
        run_prog(3);        // state 0 -> 1
        run_prog(0);        // forced exit, timeout sticky, 1 -> 2
        run_prog(LIMIT);    // halt coincides with limit, 2 -> 3
        run_prog(2);        // 3 -> 0 wrap

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Run-control sequencer sitting directly upstream of the program counter. It owns the 2-bit program-select `state` and the synchronous `pc_reset` that the PC consumes. It parks the PC at the current program's entry point, releases it on `start`, and watches for the decoder's `halt`. On completion it reports cycle count and timeout, then advances to the next program slot.

## Interface
- `CNT_W`, 16: width of the run cycle counter.
- `TIMEOUT`, 16'hFFFF: forced-finish cycle limit; 0 disables the timeout.

Ports:
- `CLK`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request to run the current program; sampled only in IDLE.
- `halt`  in  1  halt instruction reached execute; sampled only in RUN.
- `state`  out  2  program select to the PC: 0/2 → entry −1, 1/3 → entry 106.
- `pc_reset`  out  1  drives the PC `reset` input.
- `run`  out  1  processor enable (register-file/memory writes gated by this).
- `done`  out  1  one-cycle pulse marking program completion.
- `timeout`  out  1  last run ended by cycle limit rather than halt; sticky until next run.
- `cycle_count`  out  CNT_W  RUN-cycle count; live during RUN, frozen otherwise.

## Operation
FSM states are IDLE, RUN and DONE. All outputs are registered or decoded from registered state only.
- **IDLE**
  - `pc_reset=1`, `run=0`.
  - The PC reloads the entry point for `state` every cycle.
  - `start=1` → RUN; `cycle_count`←0, `timeout`←0.
- **RUN**
  - `pc_reset=0`, `run=1`.
  - `cycle_count`←`cycle_count+1` each cycle, saturating at all-ones.
  - `halt=1` → DONE.
  - Else if `TIMEOUT≠0` and `cycle_count==TIMEOUT−1` → DONE with `timeout`←1.
  - `halt` and timeout in the same cycle → DONE with `timeout=0` (halt wins).
- **DONE**
  - Lasts exactly one cycle: `done=1`, `run=0`, `pc_reset=1`.
  - `state`←`state+1` mod 4, wrapping 3→0.
  - Always → IDLE.
- **Ignored inputs**
  - `start` outside IDLE.
  - `halt` outside RUN.
  - `start`+`halt` together in IDLE: start honoured, halt ignored.
- **Reset values**, applied from any state including mid-RUN:
  - FSM=IDLE, `state=0`, `pc_reset=1`.
  - `run=0`, `done=0`, `timeout=0`, `cycle_count=0`.

## Timing
- **`start` latency:** `start` high in IDLE at edge t → RUN from t+1.
  - `pc_reset` low and `run` high from t+1.
  - The PC takes its first `pcnext_in` at edge t+2.
- **`halt` latency:** `halt` high in RUN at edge k → DONE during cycle k+1, IDLE from k+2.
  - Advanced `state` is visible from k+2.
  - Halt on the first RUN cycle gives `cycle_count=1`.
- **Count semantics:** `cycle_count` at DONE equals the number of RUN cycles, including the halt cycle.
- **Timeout:** with `TIMEOUT=N`, the count reaches N at the forced exit.
- **Back-to-back runs:** `start` high continuously gives run, DONE, IDLE (1 cycle), run.
  - The minimum gap between runs is 2 cycles.
- **Reset priority:** `reset` overrides `start`/`halt` in the same cycle.

## Structure
- **Shared package `proc_pkg`:**
  - FSM enum `run_fsm_t` {IDLE, RUN, DONE}.
  - Program-select typedef `prog_sel_t` (logic [1:0]).
  - Entry constants `PROG1_ENTRY=−1` and `PROG23_ENTRY=106`; the PC uses them too.
- **Sub-module `sat_counter`:** saturating up-counter with synchronous clear and enable, parameterised by `CNT_W`.
  - Instantiated once for `cycle_count`.

## Test plan
- **Reset:** reset mid-RUN (`state=1`, count=7) → next cycle IDLE, `state=0`, `pc_reset=1`, count=0, `run=0`.
- **Single run:** `start` at t, `halt` on the 5th RUN cycle → `done` pulse in one cycle, `cycle_count=5`, `timeout=0`, `state` 0→1.
- **Wrap:** four complete runs → `state` sequence 0,1,2,3,0; `pc_reset` high in every IDLE/DONE cycle.
- **Timeout:** `TIMEOUT=10`, no halt → DONE after 10 RUN cycles, `cycle_count=10`, `timeout=1`; next `start` clears `timeout`.
- **Ignored inputs:** `start` pulses in RUN and DONE, `halt` in IDLE → no state change, no extra `done`.
- **Simultaneous events:** `halt`+timeout same cycle (`TIMEOUT=3`, halt on 3rd cycle) → `timeout=0`. `start`+`halt` in IDLE → enters RUN.
